// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// serial_adder_pkg : state encoding and sizing helpers for serial_adder_n.
// Rev 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; a single-digit adder still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_n_digit_adder.sv
`default_nettype none
// ============================================================================
// digit_adder : combinational DIGIT-bit ripple-carry chain of full adders.
// Rev 1.0 - initial release
// ============================================================================
module digit_adder
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cmsb_o,
  output logic             cout_o
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = cin_i;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign sum_o[i]  = a_i[i] ^ b_i[i] ^ w_c[i];
      assign w_c[i+1]  = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
    end
  endgenerate

  // Carry into the top bit feeds signed-overflow detection on the last digit.
  assign cmsb_o = w_c[DIGIT-1];
  assign cout_o = w_c[DIGIT];

endmodule
`default_nettype wire

// File: rtl/serial_adder_n.sv
`default_nettype none
// ============================================================================
// serial_adder_n : digit-serial two's-complement adder, DIGIT bits per clock,
//                  Start/Busy/Done handshake. Build option SERIAL_ADDER_SUB_EN
//                  adds a sub_i port selecting A-B.
// Rev 1.0 - initial release
// ============================================================================
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int             NDIG = ndig(WIDTH, DIGIT);
  localparam int             CW   = cnt_width(NDIG);
  localparam logic [CW-1:0]  LAST = CW'(NDIG - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] w_dsum;
  logic             w_dcmsb;
  logic             w_dcout;
  logic [WIDTH-1:0] w_a_shift;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .cin_i  (carry_q),
    .sum_o  (w_dsum),
    .cmsb_o (w_dcmsb),
    .cout_o (w_dcout)
  );

  // The A register doubles as the result accumulator: sum digits enter at the
  // top as operand digits leave at the bottom, so after NDIG shifts it holds S.
  assign w_a_shift = WIDTH'({w_dsum, a_q} >> DIGIT);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start_i) begin
          state_d = ST_RUN;
          a_d     = a_i;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i | cin_i;
`else
          b_d     = b_i;
          carry_d = cin_i;
`endif
        end
      end
      ST_RUN: begin
        a_d     = w_a_shift;
        b_d     = b_q >> DIGIT;
        carry_d = w_dcout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d     = w_a_shift;
          cout_d  = w_dcout;
          ovf_d   = w_dcmsb ^ w_dcout;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);
  assign s_o    = s_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_n.sv
`default_nettype none
// ============================================================================
// tb_serial_adder_n : self-checking bench, three instances (DIGIT 1, 4, 16).
// Rev 1.0 - initial release
// ============================================================================
module tb_serial_adder_n;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   start = '0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         sub   = 1'b0;

  logic [W-1:0] s_w    [3];
  logic         busy_w [3];
  logic         done_w [3];
  logic         cout_w [3];
  logic         ovf_w  [3];

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      serial_adder_n #(
        .WIDTH (W),
        .DIGIT ((gi == 0) ? 1 : (gi == 1) ? 4 : 16)
      ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start[gi]),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub),
`endif
        .busy_o  (busy_w[gi]),
        .done_o  (done_w[gi]),
        .s_o     (s_w[gi]),
        .cout_o  (cout_w[gi]),
        .ovf_o   (ovf_w[gi])
      );
    end
  endgenerate

  function automatic int ndig_of(input int idx);
    return (idx == 0) ? 16 : (idx == 1) ? 4 : 1;
  endfunction

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    res_t         r;
    logic [W:0]   t;
    logic [W-1:0] bb;
    logic         c;
    bb     = msub ? ~mb : mb;
    c      = msub ? 1'b1 : mcin;
    t      = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c};
    r.s    = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (ma[W-1] == bb[W-1]) && (t[W-1] != ma[W-1]);
    return r;
  endfunction

  // Drive one accepted Start and wait (bounded) for Done; no checking here.
  task automatic do_op(input int idx, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tcin, input logic tsub, output res_t got,
                       output int lat, output int busy_cnt, output bit timeout);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; start[idx] = 1'b1;
    @(posedge clk); #1;
    start[idx] = 1'b0;
    busy_cnt = 0; lat = 0; timeout = 1'b1; got = '0;
    for (int k = 1; k <= 64; k++) begin
      if (busy_w[idx]) busy_cnt++;
      @(posedge clk); #1;
      if (done_w[idx]) begin
        lat     = k + 1;
        got     = {s_w[idx], cout_w[idx], ovf_w[idx]};
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst_n = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({busy_w[i], done_w[i], s_w[i], cout_w[i], ovf_w[i]} !== '0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got busy=%b done=%b s=%h cout=%b ovf=%b, want all 0",
                 i, busy_w[i], done_w[i], s_w[i], cout_w[i], ovf_w[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    n_checks++;
    if (busy_w[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL first_start: busy=%b after first edge past reset, want 1", busy_w[1]);
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (done_w[1]) seen = 1'b1;
    end
    n_checks++;
    if (!seen || s_w[1] !== 16'h0003) begin
      n_fail++;
      $display("FAIL first_result: done_seen=%b s=%h, want 1 / 0003", seen, s_w[1]);
    end
  endtask

  task automatic test_basic();
    res_t got, exp; int lat, bc; bit to;
    exp_q.push_back(model(16'h1234, 16'h4321, 1'b0, 1'b0));
    do_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, got, lat, bc, to);
    exp = exp_q.pop_front();
    n_checks++;
    if (to || got !== exp) begin
      n_fail++;
      $display("FAIL basic_result: timeout=%b got %h, want %h", to, got, exp);
    end
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges, want 5", lat);
    end
    n_checks++;
    if (bc !== 4) begin
      n_fail++;
      $display("FAIL basic_busy: busy for %0d cycles, want 4", bc);
    end
  endtask

  task automatic test_carry_ovf();
    res_t got, exp; int lat, bc; bit to;
    logic [W-1:0] va [2];
    logic [W-1:0] vb [2];
    va[0] = 16'hFFFF; vb[0] = 16'h0001;
    va[1] = 16'h7FFF; vb[1] = 16'h0001;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model(va[i], vb[i], 1'b0, 1'b0));
      do_op(1, va[i], vb[i], 1'b0, 1'b0, got, lat, bc, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (to || got !== exp) begin
        n_fail++;
        $display("FAIL carry_ovf[%0d]: timeout=%b got %h, want %h", i, to, got, exp);
      end
    end
  endtask

  task automatic test_start_ignored();
    res_t exp, got; bit seen;
    exp_q.push_back(model(16'h0F0F, 16'h0101, 1'b1, 1'b0));
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b1; sub = 1'b0; start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start[1] = 1'b1;
      @(posedge clk); #1;
      start[1] = 1'b0;
    end
    seen = 1'b0; got = '0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (done_w[1]) begin
        seen = 1'b1;
        got  = {s_w[1], cout_w[1], ovf_w[1]};
      end
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (!seen || got !== exp) begin
      n_fail++;
      $display("FAIL start_in_run: done_seen=%b got %h, want %h", seen, got, exp);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy_w[1] !== 1'b0 || done_w[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL done_to_idle: busy=%b done=%b, want 0 0", busy_w[1], done_w[1]);
    end
  endtask

  task automatic test_back_to_back();
    res_t exp1, exp2, got; int lat; bit seen;
    exp_q.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
    exp_q.push_back(model(16'hC000, 16'h4001, 1'b1, 1'b0));
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start[1] = 1'b1;
    @(posedge clk); #1;
    a = 16'hC000; b = 16'h4001; cin = 1'b1;
    seen = 1'b0; lat = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (done_w[1]) begin seen = 1'b1; lat = k + 1; end
    end
    exp1 = exp_q.pop_front();
    got  = {s_w[1], cout_w[1], ovf_w[1]};
    n_checks++;
    if (!seen || lat !== 5 || got !== exp1) begin
      n_fail++;
      $display("FAIL b2b_first: seen=%b lat=%0d got %h, want lat 5 result %h", seen, lat, got, exp1);
    end
    @(posedge clk); #1;
    start[1] = 1'b0;
    n_checks++;
    if (busy_w[1] !== 1'b1 || s_w[1] !== exp1.s) begin
      n_fail++;
      $display("FAIL b2b_no_idle: busy=%b s=%h, want busy 1 and held s %h", busy_w[1], s_w[1], exp1.s);
    end
    seen = 1'b0; lat = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (done_w[1]) begin seen = 1'b1; lat = k + 1; end
    end
    exp2 = exp_q.pop_front();
    got  = {s_w[1], cout_w[1], ovf_w[1]};
    n_checks++;
    if (!seen || lat !== 5 || got !== exp2) begin
      n_fail++;
      $display("FAIL b2b_second: seen=%b lat=%0d got %h, want lat 5 result %h", seen, lat, got, exp2);
    end
  endtask

  task automatic test_reset_mid_run();
    res_t got, exp; int lat, bc; bit to, seen;
    @(negedge clk);
    a = 16'h0123; b = 16'h0456; cin = 1'b0; sub = 1'b0; start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_w[1], done_w[1], s_w[1], cout_w[1], ovf_w[1]} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b s=%h cout=%b ovf=%b, want all 0",
               busy_w[1], done_w[1], s_w[1], cout_w[1], ovf_w[1]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done_w[1] || busy_w[1]) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_discard: busy/done seen=%b after reset, want 0", seen);
    end
    exp_q.push_back(model(16'h8001, 16'h8001, 1'b1, 1'b0));
    do_op(1, 16'h8001, 16'h8001, 1'b1, 1'b0, got, lat, bc, to);
    exp = exp_q.pop_front();
    n_checks++;
    if (to || got !== exp || lat !== 5) begin
      n_fail++;
      $display("FAIL after_reset: timeout=%b lat=%0d got %h, want lat 5 result %h", to, lat, got, exp);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    res_t got, exp; int lat, bc; bit to;
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vs [3];
    va[0] = 16'h0005; vb[0] = 16'h0007; vs[0] = 1'b1;
    va[1] = 16'h8000; vb[1] = 16'h0001; vs[1] = 1'b1;
    va[2] = 16'h0009; vb[2] = 16'h0003; vs[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(va[i], vb[i], 1'b0, vs[i]));
      do_op(1, va[i], vb[i], 1'b0, vs[i], got, lat, bc, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (to || got !== exp) begin
        n_fail++;
        $display("FAIL sub[%0d]: timeout=%b got %h, want %h", i, to, got, exp);
      end
    end
  endtask
`endif

  task automatic test_sweep();
    res_t got, exp; int lat, bc; bit to;
    logic [W-1:0] ra, rb; logic rc;
    for (int idx = 0; idx < 3; idx++) begin
      for (int it = 0; it < 1000; it++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom);
        exp_q.push_back(model(ra, rb, rc, 1'b0));
        do_op(idx, ra, rb, rc, 1'b0, got, lat, bc, to);
        exp = exp_q.pop_front();
        n_checks++;
        if (to || got !== exp) begin
          n_fail++;
          $display("FAIL sweep_result[%0d] it %0d: a=%h b=%h cin=%b timeout=%b got %h, want %h",
                   idx, it, ra, rb, rc, to, got, exp);
        end
        n_checks++;
        if (lat !== ndig_of(idx) + 1) begin
          n_fail++;
          $display("FAIL sweep_latency[%0d] it %0d: got %0d edges, want %0d",
                   idx, it, lat, ndig_of(idx) + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ovf();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder_n.md
# serial_adder_n

Digit-serial two's-complement adder, the parametrised successor of the single-bit full-adder cell. It adds two WIDTH-bit operands DIGIT bits per clock through a DIGIT-cell ripple chain, carrying between digits in a register. A Start/Busy/Done handshake lets one narrow adder serve wide datapaths: area scales with DIGIT, latency with WIDTH/DIGIT.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- Clk  input  1  sole clock; all state updates on rising edge.
- Rst_n  input  1  reset, asynchronous, active-low.
- Start  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  operand A; sampled with accepted Start.
- B  input  WIDTH  operand B; sampled with accepted Start.
- Cin  input  1  carry-in; sampled with accepted Start.
- Sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- Busy  output  1  high while digits are being processed.
- Done  output  1  one-cycle pulse when S/Cout/Ovf become valid.
- S  output  WIDTH  sum, held until the next accepted Start completes.
- Cout  output  1  carry out of bit WIDTH-1.
- Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- NDIG = WIDTH/DIGIT.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start=1 loads A, B and carry←Cin into internal registers.
  - Clears digit counter; goes to RUN.
- RUN:
  - Each edge adds the low DIGIT bits of the A and B shift registers plus the carry register.
  - Sum digit shifts into the top of the result register; A and B shift right by DIGIT.
  - Carry register ← digit carry-out; counter increments.
  - On the edge processing digit NDIG-1:
    - Cout ← final carry.
    - Ovf ← carry into MSB XOR final carry.
    - S ← completed result; state goes to DONE.
- DONE:
  - Done=1 for this cycle.
  - Start=1 is accepted exactly as in IDLE and the state goes to RUN; otherwise the state goes to IDLE.
- Start in RUN is ignored; operands are not resampled.
- S, Cout and Ovf change only on the final RUN edge. They are stable in IDLE and DONE and during a following RUN.
- Arithmetic is modulo 2^WIDTH. Cout is the unsigned carry; Ovf is the signed overflow.

## Timing
- Reset (asynchronous, any time, including mid-RUN):
  - State goes to IDLE.
  - Busy=0, Done=0, S=0, Cout=0, Ovf=0.
  - Counter and carry cleared.
  - The in-flight operation is discarded and produces no Done.
- Start sampled at edge 0:
  - Busy=1 after edge 0 through edge NDIG-1.
  - Done=1 between edges NDIG and NDIG+1.
- Latency Start→Done = NDIG+1 edges. Back-to-back throughput is one result per NDIG+1 cycles.
- DIGIT=WIDTH gives NDIG=1: Done follows Start by 2 edges.
- Rst_n deassertion is synchronised externally. The first Start is honoured on the first edge after release.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Sub port exists.
  - Accepted Start with Sub=1 loads B inverted and forces carry←1, ignoring Cin. The result is A−B.
  - Cout=1 means no borrow; Ovf is the signed overflow of the subtraction.
- Macro undefined:
  - No Sub port; add-only.
  - Cin always used.

## Structure
- Shared package serial_adder_pkg holds:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the NDIG derivation;
  - the counter-width function clog2(NDIG), minimum 1.
- Sub-module digit_adder:
  - combinational DIGIT-bit ripple chain of full-adder cells;
  - outputs the sum digit, the carry into the top bit (for Ovf) and the carry out.
- Top level holds the FSM, shift registers, counter and output registers.

## Test plan
All cases use WIDTH=16, DIGIT=4 unless stated.

- A=0x1234, B=0x4321, Cin=0 → S=0x5555, Cout=0, Ovf=0; Done exactly 5 edges after the Start edge; Busy high for 4 cycles.
- A=0xFFFF, B=0x0001, Cin=0 → S=0x0000, Cout=1, Ovf=0. A=0x7FFF, B=0x0001 → S=0x8000, Cout=0, Ovf=1.
- Start pulses during RUN with different operands → ignored, S=first result. Start held high in DONE → second operation begins with no IDLE cycle and completes 5 edges later.
- Rst_n low after RUN edge 2 → all outputs 0 immediately; no Done; a new Start then completes normally.
- With SERIAL_ADDER_SUB_EN: A=0x0005, B=0x0007, Sub=1 → S=0xFFFE, Cout=0. A=0x8000, B=0x0001, Sub=1 → S=0x7FFF, Ovf=1.
- Parameter sweep DIGIT∈{1,4,16}: 1000 random A/B/Cin → S/Cout/Ovf match a reference model; Done latency = WIDTH/DIGIT+1.
